// File: rtl/pipeline_stall_ctrl.sv
// Purpose: central stall controller; merges IF/ID/EX/MEM stall causes into a prefix stall vector, owns MDU counter and MEM watchdog.
// Latency: stall and mdu_done are combinational from inputs/state (zero cycles); mem_timeout is registered (one cycle).
// Backpressure: the highest active stage cause stalls itself and every earlier stage; a MEM wait is force-released after MEM_TIMEOUT cycles.
module pipeline_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rom_en,
    input  logic       rom_ready,
    input  logic       id_load_use,
    input  logic       ex_mdu_start,
    input  logic       ram_en,
    input  logic       ram_ready,
    output logic [4:0] stall,
    output logic       mdu_busy,
    output logic       mdu_done,
    output logic       mem_timeout
);

    localparam int MCW = $clog2(MDU_LATENCY + 1);
    localparam int WCW = $clog2(MEM_TIMEOUT);
    localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LATENCY - 1);
    localparam logic [MCW-1:0] MDU_ONE  = MCW'(1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_BUSY,
        MDU_DONE
    } mdu_state_t;

    mdu_state_t     mdu_state;
    mdu_state_t     mdu_state_nxt;
    logic [MCW-1:0] mdu_cnt;
    logic [MCW-1:0] mdu_cnt_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           mem_timeout_q;

    logic           if_req;
    logic           id_req;
    logic           ex_req;
    logic           mem_req;
    logic [4:0]     stall_raw;

    // Stall causes; each cause holds its own stage and everything upstream.
    always_comb begin
        if_req    = rom_en & ~rom_ready;
        id_req    = id_load_use;
        ex_req    = ((mdu_state == MDU_IDLE) & ex_mdu_start) | (mdu_state == MDU_BUSY);
        mem_req   = ram_en & ~ram_ready & ~mem_timeout_q;
        stall_raw = ({5{if_req}}  & 5'b00011)
                  | ({5{id_req}}  & 5'b00111)
                  | ({5{ex_req}}  & 5'b01111)
                  | ({5{mem_req}} & 5'b11111);
    end

    // Outputs are forced quiet while reset is held, independent of state.
    always_comb begin
        stall       = rst ? stall_raw : 5'b0;
        mdu_busy    = rst & (mdu_state != MDU_IDLE);
        mdu_done    = rst & (mdu_state == MDU_DONE);
        mem_timeout = rst & mem_timeout_q;
    end

    // MDU next-state: hold EX for MDU_LATENCY cycles, then present the result;
    // DONE is held while MEM stalls so the same instruction cannot restart.
    always_comb begin
        mdu_state_nxt = mdu_state;
        mdu_cnt_nxt   = mdu_cnt;
        case (mdu_state)
            MDU_IDLE: begin
                if (ex_mdu_start) begin
                    mdu_cnt_nxt   = MDU_LOAD;
                    mdu_state_nxt = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (mdu_cnt == MDU_ONE) begin
                    mdu_state_nxt = MDU_DONE;
                end else begin
                    mdu_cnt_nxt = mdu_cnt - MDU_ONE;
                end
            end
            MDU_DONE: begin
                if (!mem_req) begin
                    mdu_state_nxt = MDU_IDLE;
                end
            end
            default: begin
                mdu_state_nxt = MDU_IDLE;
            end
        endcase
    end

    // MDU state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mdu_state <= MDU_IDLE;
            mdu_cnt   <= '0;
        end else begin
            mdu_state <= mdu_state_nxt;
            mdu_cnt   <= mdu_cnt_nxt;
        end
    end

    // Data-memory watchdog: count consecutive wait cycles, pulse a release after MEM_TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
        end else if (mem_req) begin
            if (wait_cnt == WAIT_MAX) begin
                wait_cnt      <= '0;
                mem_timeout_q <= 1'b1;
            end else begin
                wait_cnt      <= wait_cnt + WAIT_ONE;
                mem_timeout_q <= 1'b0;
            end
        end else begin
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Purpose: self-checking bench for pipeline_stall_ctrl with a per-cycle expected-output scoreboard.
// Latency: outputs compared on the falling edge of the cycle they are expected in.
// Backpressure: not applicable; stimulus is a fixed cycle script.
module tb_pipeline_stall_ctrl;

    localparam int LAT = 4;
    localparam int TMO = 16;

    logic       clk;
    logic       rst;
    logic       rom_en;
    logic       rom_ready;
    logic       id_load_use;
    logic       ex_mdu_start;
    logic       ram_en;
    logic       ram_ready;
    logic [4:0] stall;
    logic       mdu_busy;
    logic       mdu_done;
    logic       mem_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    pipeline_stall_ctrl #(
        .MDU_LATENCY(LAT),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_ready   (rom_ready),
        .id_load_use (id_load_use),
        .ex_mdu_start(ex_mdu_start),
        .ram_en      (ram_en),
        .ram_ready   (ram_ready),
        .stall       (stall),
        .mdu_busy    (mdu_busy),
        .mdu_done    (mdu_done),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got stall=%b busy=%b done=%b tmo=%b, want stall=%b busy=%b done=%b tmo=%b",
                     tag, obs[7:3], obs[2], obs[1], obs[0], expv[7:3], expv[2], expv[1], expv[0]);
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, compare at the falling edge.
    task automatic cyc(input string tag, input logic r, input logic re, input logic rr,
                       input logic lu, input logic xs, input logic me, input logic mr,
                       input logic [4:0] e_stall, input logic e_busy, input logic e_done,
                       input logic e_tmo);
        logic [7:0] e;
        string      t;
        rst          = r;
        rom_en       = re;
        rom_ready    = rr;
        id_load_use  = lu;
        ex_mdu_start = xs;
        ram_en       = me;
        ram_ready    = mr;
        exp_q.push_back({e_stall, e_busy, e_done, e_tmo});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {stall, mdu_busy, mdu_done, mem_timeout}, e);
        @(posedge clk);
        #1;
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rom_en = 1'b0; rom_ready = 1'b0; id_load_use = 1'b0;
        ex_mdu_start = 1'b0; ram_en = 1'b0; ram_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset and idle
        cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 0);
        cyc("idle0",  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("idle1",  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // load-use pulse and fetch wait
        cyc("loaduse",    1, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 0, 0);
        cyc("loaduse_end",1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("ifwait",     1, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0);
        cyc("ifready",    1, 1, 1, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // two back-to-back MDU ops with start held continuously
        for (int op = 0; op < 2; op++) begin
            cyc("mdu_start", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
            for (int k = 1; k < LAT; k++)
                cyc("mdu_busy", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 1, 0, 0);
            cyc("mdu_done", 1, 0, 0, 0, 1, 0, 0, 5'b00000, 1, 1, 0);
        end
        cyc("mdu_idle", 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // reset while an MDU start is asserted abandons the op
        cyc("rst_mid_start", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("rst_mid_held",  0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0);
        cyc("rst_mid_after", 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // MEM wait overlapping the done cycle holds DONE, then no restart
        cyc("dm_start", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        for (int k = 1; k < LAT; k++)
            cyc("dm_busy", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("dm_memwait", 1, 0, 0, 0, 1, 1, 0, 5'b11111, 1, 1, 0);
        cyc("dm_release", 1, 0, 0, 0, 1, 1, 1, 5'b00000, 1, 1, 0);
        cyc("dm_norestart", 1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // MEM wait during BUSY does not freeze the MDU count
        cyc("bm_start", 1, 0, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("bm_wait1", 1, 0, 0, 0, 1, 1, 0, 5'b11111, 1, 0, 0);
        cyc("bm_wait2", 1, 0, 0, 0, 1, 1, 0, 5'b11111, 1, 0, 0);
        cyc("bm_ready", 1, 0, 0, 0, 1, 1, 1, 5'b01111, 1, 0, 0);
        cyc("bm_done",  1, 0, 0, 0, 1, 0, 0, 5'b00000, 1, 1, 0);
        cyc("bm_idle",  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // watchdog: stuck memory stalls exactly TMO cycles, then releases, then restarts
        for (int k = 0; k < TMO; k++)
            cyc("to_wait", 1, 0, 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("to_pulse",   1, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 1);
        cyc("to_restart", 1, 0, 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("to_ready",   1, 0, 0, 0, 0, 1, 1, 5'b00000, 0, 0, 0);
        cyc("to_idle",    1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // ready on the 5th wait cycle while load-use is active
        for (int k = 0; k < 4; k++)
            cyc("rl_wait", 1, 0, 0, 1, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("rl_ready", 1, 0, 0, 1, 0, 1, 1, 5'b00111, 0, 0, 0);

        // a fresh full-length wait proves the wait counter restarted from zero
        for (int k = 0; k < TMO; k++)
            cyc("fw_wait", 1, 0, 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("fw_pulse", 1, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 1);
        cyc("fw_idle",  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        // reset during a memory wait leaves no pending timeout
        for (int k = 0; k < TMO - 2; k++)
            cyc("rw_wait", 1, 0, 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("rw_reset", 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc("rw_after", 1, 0, 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0);
        cyc("rw_ready", 1, 0, 0, 0, 0, 1, 1, 5'b00000, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
